// File: rtl/slc3_mem_pkg.sv
// slc3_mem_pkg: shared types and constants for the SLC-3 SRAM access sequencer.
//   state_t   - sequencer states (IDLE, SETUP, ACCESS, DONE)
//   MMIO_ADDR - word address decoded as the switch/hex I/O word
//   WAIT_MIN / WAIT_MAX - legal range of the wait-state parameter
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] MMIO_ADDR = 16'hFFFF;
    localparam int          WAIT_MIN  = 1;
    localparam int          WAIT_MAX  = 15;

    function automatic logic is_mmio(input logic [15:0] a);
        return (a == MMIO_ADDR);
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: datapath-side request/acknowledge bus of the SRAM sequencer.
//   req, we, addr, wdata - request from the datapath (MAR/MDR side)
//   rdata, ack, busy     - completion data and status back to the datapath
// master = datapath, slave = sram_ctrl.
interface sram_ctrl_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;
    logic        busy;

    modport master (output req, we, addr, wdata, input rdata, ack, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/sram_ctrl_mmio.sv
// sram_ctrl_mmio: memory-mapped I/O word for the SRAM sequencer.
// Present only when SRAM_CTRL_MMIO_EN is defined.
//   Clk, Reset     - clock, synchronous active-high reset
//   addr, wdata    - latched request address / write data
//   hex_load       - write-completion strobe from the sequencer
//   Switches       - board switches, read source for the I/O word
//   Data_from_SRAM - SRAM read data for ordinary addresses
//   rd_data        - read data selected for the current access
//   hex_out        - hex display register, written via the I/O word
`ifdef SRAM_CTRL_MMIO_EN
module sram_ctrl_mmio
    import slc3_mem_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        hex_load,
    input  logic [15:0] Switches,
    input  logic [15:0] Data_from_SRAM,
    output logic [15:0] rd_data,
    output logic [15:0] hex_out
);

    logic io_sel;

    assign io_sel  = is_mmio(addr);
    assign rd_data = io_sel ? Switches : Data_from_SRAM;

    always_ff @(posedge Clk) begin
        if (Reset)
            hex_out <= 16'h0000;
        else if (hex_load && io_sel)
            hex_out <= wdata;
    end

endmodule
`endif

// File: rtl/sram_ctrl.sv
// sram_ctrl: handshaked SRAM access sequencer for the SLC-3 datapath.
// Sequence per access: IDLE -> SETUP (1) -> ACCESS (WAIT_CYCLES) -> DONE (1).
//   Clk, Reset           - clock, synchronous active-high reset
//   bus (slave)          - req/we/addr/wdata in, rdata/ack/busy out
//   Switches, hex_out    - MMIO switch input / hex display output
//   Mem_CE/UB/LB/OE/WE   - active-low SRAM strobes (registered)
//   ADDR, Data_to_SRAM   - SRAM address and write data (latched)
//   Data_from_SRAM       - SRAM read data from the tristate buffer
//   drive_en             - tristate enable, CPU drives the data bus
// Optional macro SRAM_CTRL_MMIO_EN: address 16'hFFFF becomes the switch/hex
// I/O word; without it hex_out is tied low and Switches is unused.
module sram_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    sram_ctrl_if.slave  bus,
    input  logic [15:0] Switches,
    output logic [15:0] hex_out,
    output logic        Mem_CE,
    output logic        Mem_UB,
    output logic        Mem_LB,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [19:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    input  logic [15:0] Data_from_SRAM,
    output logic        drive_en
);

    if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
        $error("sram_ctrl: WAIT_CYCLES must be within 1..15");
    end

    state_t      state;
    logic [3:0]  cnt;
    logic        we_l;
    logic        io_l;
    logic [15:0] addr_l;
    logic [15:0] wdata_l;
    logic [15:0] rdata_q;
    logic        ack_q;
    logic        busy_q;
    logic        io_req;
    logic [15:0] rd_src;

`ifdef SRAM_CTRL_MMIO_EN
    logic hex_load;

    assign io_req   = is_mmio(bus.addr);
    assign hex_load = (state == DONE) && we_l;

    sram_ctrl_mmio u_mmio (
        .Clk            (Clk),
        .Reset          (Reset),
        .addr           (addr_l),
        .wdata          (wdata_l),
        .hex_load       (hex_load),
        .Switches       (Switches),
        .Data_from_SRAM (Data_from_SRAM),
        .rd_data        (rd_src),
        .hex_out        (hex_out)
    );
`else
    logic unused_switches;

    assign io_req          = 1'b0;
    assign rd_src          = Data_from_SRAM;
    assign hex_out         = 16'h0000;
    assign unused_switches = ^Switches;
`endif

    assign ADDR         = {4'h0, addr_l};
    assign Data_to_SRAM = wdata_l;
    assign bus.rdata    = rdata_q;
    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;

    // Outputs are set for the state being entered, so every strobe is a flop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            we_l     <= 1'b0;
            io_l     <= 1'b0;
            addr_l   <= 16'h0000;
            wdata_l  <= 16'h0000;
            rdata_q  <= 16'h0000;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            Mem_CE   <= 1'b1;
            Mem_UB   <= 1'b1;
            Mem_LB   <= 1'b1;
            Mem_OE   <= 1'b1;
            Mem_WE   <= 1'b1;
            drive_en <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        state   <= SETUP;
                        busy_q  <= 1'b1;
                        we_l    <= bus.we;
                        io_l    <= io_req;
                        addr_l  <= bus.addr;
                        wdata_l <= bus.wdata;
                        cnt     <= 4'(WAIT_CYCLES - 1);
                        Mem_CE  <= io_req;
                        Mem_UB  <= io_req;
                        Mem_LB  <= io_req;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    if (!io_l) begin
                        if (we_l) begin
                            Mem_WE   <= 1'b0;
                            drive_en <= 1'b1;
                        end else begin
                            Mem_OE   <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state  <= DONE;
                        ack_q  <= 1'b1;
                        Mem_OE <= 1'b1;
                        Mem_WE <= 1'b1;
                        if (!we_l)
                            rdata_q <= rd_src;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy_q   <= 1'b0;
                    Mem_CE   <= 1'b1;
                    Mem_UB   <= 1'b1;
                    Mem_LB   <= 1'b1;
                    drive_en <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed self-checking bench for sram_ctrl (WAIT_CYCLES = 2).
// Cycle k is the interval after clock edge k; a request driven in cycle 0 is
// accepted on the following edge, so ack is expected in cycle 4.
module tb_sram_ctrl;

`ifdef SRAM_CTRL_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Switches;
    logic [15:0] hex_out;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic [19:0] ADDR;
    logic [15:0] Data_to_SRAM;
    logic [15:0] Data_from_SRAM;
    logic        drive_en;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:255];

    sram_ctrl_if bus ();

    sram_ctrl #(.WAIT_CYCLES(2)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .bus            (bus.slave),
        .Switches       (Switches),
        .hex_out        (hex_out),
        .Mem_CE         (Mem_CE),
        .Mem_UB         (Mem_UB),
        .Mem_LB         (Mem_LB),
        .Mem_OE         (Mem_OE),
        .Mem_WE         (Mem_WE),
        .ADDR           (ADDR),
        .Data_to_SRAM   (Data_to_SRAM),
        .Data_from_SRAM (Data_from_SRAM),
        .drive_en       (drive_en)
    );

    always #5 Clk = ~Clk;

    // SRAM model: 256 words, write while WE low and bus driven, async read.
    always @(posedge Clk)
        if (!Mem_WE && !Mem_CE && drive_en)
            mem[ADDR[7:0]] <= Data_to_SRAM;
    assign Data_from_SRAM = Mem_OE ? 16'h0000 : mem[ADDR[7:0]];

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access with the full strobe timeline checked.
    // io: address expected to decode as the I/O word.
    // exp_rd: rdata expected at ack (previous value for writes).
    task automatic access(input string tag, input bit w, input logic [15:0] a,
                          input logic [15:0] d, input bit io, input logic [15:0] exp_rd);
        logic we_exp;
        logic oe_exp;
        we_exp = !(w && !io);
        oe_exp = !(!w && !io);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        tick;                                         // cycle 1: SETUP
        bus.req = 1'b0; bus.addr = 16'h5555; bus.wdata = 16'h0000;
        chk({tag, " c1 busy"}, 32'(bus.busy), 32'd1);
        chk({tag, " c1 ce_ub_lb"}, 32'({Mem_CE, Mem_UB, Mem_LB}), 32'({3{io}}));
        chk({tag, " c1 oe_we"}, 32'({Mem_OE, Mem_WE}), 32'b11);
        chk({tag, " c1 drive_en"}, 32'(drive_en), 32'd0);
        chk({tag, " c1 ADDR"}, 32'(ADDR), 32'({4'h0, a}));
        tick;                                         // cycle 2: ACCESS
        chk({tag, " c2 oe_we"}, 32'({Mem_OE, Mem_WE}), 32'({oe_exp, we_exp}));
        chk({tag, " c2 drive_en"}, 32'(drive_en), 32'(w && !io));
        chk({tag, " c2 data"}, 32'(Data_to_SRAM), 32'(d));
        chk({tag, " c2 ack"}, 32'(bus.ack), 32'd0);
        tick;                                         // cycle 3: ACCESS
        chk({tag, " c3 oe_we"}, 32'({Mem_OE, Mem_WE}), 32'({oe_exp, we_exp}));
        chk({tag, " c3 ADDR"}, 32'(ADDR), 32'({4'h0, a}));
        tick;                                         // cycle 4: DONE
        chk({tag, " c4 ack"}, 32'(bus.ack), 32'd1);
        chk({tag, " c4 oe_we"}, 32'({Mem_OE, Mem_WE}), 32'b11);
        chk({tag, " c4 ce"}, 32'(Mem_CE), 32'(io));
        chk({tag, " c4 drive_en"}, 32'(drive_en), 32'(w && !io));
        chk({tag, " c4 rdata"}, 32'(bus.rdata), 32'(exp_rd));
        tick;                                         // cycle 5: IDLE
        chk({tag, " c5 ack"}, 32'(bus.ack), 32'd0);
        chk({tag, " c5 busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " c5 strobes"}, 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'h1F);
        chk({tag, " c5 drive_en"}, 32'(drive_en), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        Reset = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 16'h0000; bus.wdata = 16'h0000;
        Switches = 16'h00A5;

        // Reset state
        tick; tick;
        Reset = 1'b0;
        chk("rst strobes", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'h1F);
        chk("rst drive_en", 32'(drive_en), 32'd0);
        chk("rst busy_ack", 32'({bus.busy, bus.ack}), 32'd0);
        chk("rst rdata", 32'(bus.rdata), 32'h0000);
        chk("rst hex_out", 32'(hex_out), 32'h0000);
        chk("rst ADDR", 32'(ADDR), 32'h00000);
        tick;
        chk("idle busy", 32'(bus.busy), 32'd0);

        // Write then read back
        access("wr40", 1'b1, 16'h0040, 16'hBEEF, 1'b0, 16'h0000);
        chk("wr40 mem", 32'(mem[8'h40]), 32'hBEEF);
        access("rd40", 1'b0, 16'h0040, 16'h0000, 1'b0, 16'hBEEF);

        // req held high: accepted every 5 cycles, mid-access addr change ignored
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0040;
        tick;                                               // c1
        chk("b2b c1 ADDR", 32'(ADDR), 32'h00040);
        tick;                                               // c2
        bus.addr = 16'h0041;
        tick;                                               // c3
        chk("b2b c3 ADDR", 32'(ADDR), 32'h00040);
        tick;                                               // c4
        chk("b2b c4 ack", 32'(bus.ack), 32'd1);
        chk("b2b c4 rdata", 32'(bus.rdata), 32'hBEEF);
        tick;                                               // c5
        chk("b2b c5 ack_busy", 32'({bus.ack, bus.busy}), 32'b00);
        tick;                                               // c6
        chk("b2b c6 busy", 32'(bus.busy), 32'd1);
        chk("b2b c6 ADDR", 32'(ADDR), 32'h00041);
        tick; tick;                                         // c7, c8
        chk("b2b c8 ack", 32'(bus.ack), 32'd0);
        tick;                                               // c9
        chk("b2b c9 ack", 32'(bus.ack), 32'd1);
        chk("b2b c9 rdata", 32'(bus.rdata), 32'h1041);
        bus.req = 1'b0;
        tick;                                               // c10
        chk("b2b c10 busy", 32'(bus.busy), 32'd0);
        tick;                                               // c11
        chk("b2b c11 busy", 32'(bus.busy), 32'd0);

        // I/O word (ordinary SRAM word when the decode is not built)
        access("wrFFFF", 1'b1, 16'hFFFF, 16'h1234, MMIO, 16'h1041);
        chk("hex_out", 32'(hex_out), MMIO ? 32'h1234 : 32'h0000);
        access("rdFFFF", 1'b0, 16'hFFFF, 16'h0000, MMIO, MMIO ? 16'h00A5 : 16'h1234);
        chk("hex_out hold", 32'(hex_out), MMIO ? 32'h1234 : 32'h0000);

        // Reset during ACCESS of a write
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h0050; bus.wdata = 16'h1111;
        tick;                                               // c1
        bus.req = 1'b0;
        tick;                                               // c2
        chk("rst_mid c2 we", 32'(Mem_WE), 32'd0);
        Reset = 1'b1;
        tick;                                               // c3
        Reset = 1'b0;
        chk("rst_mid strobes", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'h1F);
        chk("rst_mid drive_en", 32'(drive_en), 32'd0);
        chk("rst_mid busy_ack", 32'({bus.busy, bus.ack}), 32'd0);
        chk("rst_mid ADDR", 32'(ADDR), 32'h00000);
        chk("rst_mid rdata", 32'(bus.rdata), 32'h0000);
        tick;                                               // c4
        chk("rst_mid c4 ack", 32'(bus.ack), 32'd0);

        // Recovery after reset
        access("rd41", 1'b0, 16'h0041, 16'h0000, 1'b0, 16'h1041);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Handshaked SRAM access sequencer sitting between the SLC-3 datapath (MAR/MDR) and the external 1Mx16 SRAM tristate interface. Replaces fixed-length memory states in the control unit with a req/ack protocol and a configurable wait-state count, generates the active-low SRAM strobes and the tristate drive enable, and optionally decodes a memory-mapped switch/hex I/O word. Downstream of the datapath, upstream of the 16-bit tristate buffer and SRAM pins.

## Interface
- WAIT_CYCLES, 2, cycles OE/WE held asserted per access; legal 1..15
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- req  in  1  access request, sampled only in IDLE
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  16  word address; sampled with req
- wdata  in  16  write data; sampled with req
- rdata  out  16  read data, valid from ack cycle until next read completes
- ack  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- Switches  in  16  board switches (MMIO read source)
- hex_out  out  16  four hex-digit nibbles (MMIO write target)
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low
- ADDR  out  20  SRAM address, {4'h0, latched addr}
- Data_to_SRAM  out  16  latched wdata
- Data_from_SRAM  in  16  data returned by tristate buffer
- drive_en  out  1  tristate output enable (CPU drives bus)

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: strobes high, drive_en 0, ack 0. req=1 -> latch we/addr/wdata, go SETUP.
- SETUP (1 cycle): Mem_CE, Mem_UB, Mem_LB low; ADDR valid; OE/WE high; wait counter loaded with WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles): read -> Mem_OE low; write -> Mem_WE low, drive_en 1. Counter decrements; at 0 go DONE. Read captures Data_from_SRAM into rdata on the final ACCESS edge.
- DONE (1 cycle): OE/WE high; CE/UB/LB remain low; write keeps drive_en 1 (data hold); ack=1; next state IDLE.
- req outside IDLE ignored; no queuing. Latched inputs are immune to changes after acceptance.
- Counter 4-bit, no wrap: loaded value always < WAIT_CYCLES.
- Reset (any state, including mid-access): next edge -> IDLE; all strobes high, drive_en 0, ack 0, busy 0, rdata 16'h0000, hex_out 16'h0000, ADDR 0, Data_to_SRAM 0.

## Timing
- req high in IDLE at edge N -> ack high in cycle N+2+WAIT_CYCLES (single cycle).
- Minimum request spacing: 3+WAIT_CYCLES cycles (req accepted again in IDLE following DONE).
- busy rises cycle after acceptance, falls on the IDLE following DONE.
- Write: address stable one cycle before WE falls and one cycle after WE rises; data driven for whole ACCESS+DONE.
- Read: rdata updated together with ack rising; holds thereafter.

## Configuration
- SRAM_CTRL_MMIO_EN defined: addr == 16'hFFFF is I/O. Same state sequence and latency, but Mem_CE/UB/LB/OE/WE stay high and drive_en stays 0. Read returns Switches (sampled on final ACCESS edge). Write loads hex_out from latched wdata on the DONE edge.
- Undefined: no decode; 16'hFFFF is an ordinary SRAM word; hex_out tied 16'h0000, Switches unused.

## Structure
- Package slc3_mem_pkg: state enum (IDLE, SETUP, ACCESS, DONE), MMIO_ADDR = 16'hFFFF, WAIT_MIN = 1, WAIT_MAX = 15.
- Sub-module sram_ctrl_mmio (only under SRAM_CTRL_MMIO_EN): address decode, hex_out register, switch read mux.
- Parameter range checked by elaboration-time assertion.

## Test plan
- Reset then idle -> all strobes 1, drive_en 0, busy 0, rdata 0, hex_out 0.
- WAIT_CYCLES=2, write addr 16'h0040 wdata 16'hBEEF at cycle 0 -> Mem_WE low cycles 2-3, drive_en cycles 2-4, ack at cycle 4, ADDR 20'h00040.
- Read back 16'h0040 with SRAM model returning 16'hBEEF -> Mem_OE low cycles 2-3, rdata 16'hBEEF with ack at cycle 4.
- req held high continuously -> accepts every 5 cycles (WAIT_CYCLES=2); changes to addr mid-access have no effect on ADDR.
- MMIO_EN: write 16'h1234 to 16'hFFFF -> hex_out 16'h1234 after ack, no SRAM strobe; read 16'hFFFF with Switches 16'h00A5 -> rdata 16'h00A5.
- Reset asserted during ACCESS of a write -> next cycle Mem_WE 1, drive_en 0, no ack, busy 0.
